ysyx_25040129_imem_rd_slave: RTL and testbench
==============================================

// Module: ysyx_25040129_imem_rd_slave
// PURPOSE
//  AXI4-Lite read-channel responder (AR + R only) backing the fetch-side master with a word memory.
//  Sits on the instruction bus as the memory end of the fetch interface.
//  Provides fixed or pseudo-random response latency, so master stall paths are exercised.
//  Reports decode errors on rresp; a backdoor write port lets the bench load and patch memory.
// PARAMETERS
//  BASE_ADDR   32'h3000_0000  byte address of word 0 (equals FLASH_START)
//  DEPTH       1024           memory size in 32-bit words (power of 2)
//  LATENCY     1              extra wait cycles D when RAND_DELAY=0 (0..15)
//  RAND_DELAY  0              1: D taken from LFSR each transaction
//  MAX_DELAY   7              clamp for random D (0..15)
//  LFSR_SEED   16'hACE1       LFSR reset value (nonzero)
//  INIT_FILE   ""             $readmemh image; empty = no preload
// PORTS
//  clk      in   1   clock, all logic on posedge
//  rst      in   1   synchronous reset, active-high
//  araddr   in   32  read byte address
//  arvalid  in   1   read address valid
//  arready  out  1   read address ready
//  rdata    out  32  read data
//  rresp    out  2   00 OKAY, 10 SLVERR, 11 DECERR
//  rvalid   out  1   read data valid
//  rready   in   1   read data ready
//  wr_en    in   1   backdoor word write strobe (bench/loader only)
//  wr_addr  in   32  backdoor byte address (same decode as araddr)
//  wr_data  in   32  backdoor write data
// BEHAVIOUR
//  Reset: state=IDLE, rvalid=0, rdata=0, rresp=00, counter=0, lfsr=LFSR_SEED; arready=0 in rst cycle.
//   Memory contents are not reset. Reset mid-transaction drops it silently; no R beat is issued.
//  FSM IDLE -> DELAY -> RESP -> IDLE. arready = (state==IDLE) && !rst; it is low in DELAY and RESP.
//  IDLE: on arvalid, latch araddr, load cnt=D.
//   Go to RESP if D==0, otherwise go to DELAY.
//  DELAY: cnt decrements each cycle; at cnt==1 go to RESP.
//  Entering RESP, register rdata and rresp; rvalid=1 from the next cycle.
//   => rvalid rises exactly 1+D cycles after the AR handshake cycle (never in the same cycle).
//  RESP: rdata, rresp, rvalid held stable until rready. On rvalid&&rready -> IDLE, rvalid=0.
//   New AR is accepted only on the cycle after that (one request outstanding, no overlap).
//  arvalid outside IDLE is ignored. The master must hold araddr until arready.
//  Decode (priority order):
//   - araddr[1:0]!=0: rresp=10, rdata=0.
//   - araddr<BASE_ADDR or araddr>=BASE_ADDR+DEPTH*4: rresp=11, rdata=0.
//   - otherwise: rresp=00, rdata=mem[(araddr-BASE_ADDR)>>2]; index width = clog2(DEPTH).
//  Random delay: 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every non-reset cycle.
//   D = min(lfsr[3:0], MAX_DELAY).
//  Backdoor write: on wr_en, mem[idx(wr_addr)] <= wr_data. Ignored if wr_addr is misaligned or out of range.
//   Write and data capture in the same cycle to the same word: the read returns old data (read-before-write).
//   A write landing during DELAY is visible to that pending read.
//  Error responses complete the handshake normally; no sticky error state.
// TESTING
//  1. LATENCY=0: AR 0x3000_0000 accepted at cycle t, mem[0]=0x0000_0413
//     -> rvalid at t+1, rdata=0x0000_0413, rresp=00.
//  2. LATENCY=3, rready held low 4 cycles after rvalid
//     -> rvalid at t+4; rdata/rresp stable until rready; arready=0 throughout.
//  3. AR 0x3000_0002 -> rresp=10, rdata=0.
//     AR 0x3000_1000 (DEPTH=1024) -> rresp=11, rdata=0.
//     AR 0x2FFF_FFFC -> rresp=11, rdata=0.
//  4. RAND_DELAY=1, MAX_DELAY=7, 1000 back-to-back fetches
//     -> every D in 0..7, all data matches the model, no lost or duplicate beats.
//  5. rst asserted during DELAY
//     -> next cycle rvalid=0, state IDLE; first post-reset AR returns correct data.
//  6. wr_en to 0x3000_0010 in DELAY while a read of the same address is pending
//     -> response shows new data. Same write in the capture cycle -> old data.

Source files
------------

// File: rtl/ysyx_25040129_imem_rd_slave.sv
// AXI4-Lite read-only memory responder for the instruction fetch bus.
// Has fixed or LFSR-driven response latency and a backdoor word-write port for loading and patching.
module ysyx_25040129_imem_rd_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          DEPTH      = 1024,
    parameter int          LATENCY    = 1,
    parameter bit          RAND_DELAY = 1'b0,
    parameter int          MAX_DELAY  = 7,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
);

    localparam int          IDX_W       = $clog2(DEPTH);
    localparam logic [31:0] END_ADDR    = BASE_ADDR + 32'(DEPTH) * 32'd4;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_RESP
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [15:0] lfsr_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rvalid_q;
    logic [31:0] mem_q [DEPTH];

    logic [15:0] lfsr_d;
    logic [3:0]  delay_d;
    logic [31:0] cap_addr_d;
    logic [1:0]  cap_resp_d;
    logic [31:0] cap_data_d;
    logic        wr_ok_d;

    // Misalignment outranks the range check.
    function automatic logic [1:0] decode_resp(input logic [31:0] a);
        if (a[1:0] != 2'b00) begin
            return RESP_SLVERR;
        end else if (a < BASE_ADDR || a >= END_ADDR) begin
            return RESP_DECERR;
        end
        return RESP_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a value first, so no path can infer a latch.
        lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        delay_d    = 4'(LATENCY);
        if (RAND_DELAY) begin
            delay_d = (lfsr_q[3:0] > 4'(MAX_DELAY)) ? 4'(MAX_DELAY) : lfsr_q[3:0];
        end
        // With zero delay the response is captured in the AR handshake cycle itself.
        cap_addr_d = (state_q == S_IDLE) ? araddr : addr_q;
        cap_resp_d = decode_resp(cap_addr_d);
        cap_data_d = '0;
        if (cap_resp_d == RESP_OKAY) begin
            cap_data_d = mem_q[word_idx(cap_addr_d)];
        end
        wr_ok_d    = wr_en && (decode_resp(wr_addr) == RESP_OKAY);
    end

    // NOTE: the memory array has no reset; contents survive rst and only the backdoor port writes them.
    always_ff @(posedge clk) begin
        if (wr_ok_d) begin
            mem_q[word_idx(wr_addr)] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            lfsr_q   <= LFSR_SEED;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            unique case (state_q)
                S_IDLE: begin
                    if (arvalid) begin
                        addr_q <= araddr;
                        cnt_q  <= delay_d;
                        if (delay_d == 4'd0) begin
                            state_q  <= S_RESP;
                            rvalid_q <= 1'b1;
                            rdata_q  <= cap_data_d;
                            rresp_q  <= cap_resp_d;
                        end else begin
                            state_q <= S_DELAY;
                        end
                    end
                end
                S_DELAY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q  <= S_RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= cap_data_d;
                        rresp_q  <= cap_resp_d;
                    end
                end
                S_RESP: begin
                    if (rready) begin
                        state_q  <= S_IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign arready = (state_q == S_IDLE) && !rst;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rvalid  = rvalid_q;

endmodule

// File: tb/tb_ysyx_25040129_imem_rd_slave.sv
// Bench for the fetch-side read slave: three instances (latency 0, latency 3, random latency)
// checked against a word-array memory model, address decode rules and an LFSR-derived delay model.
module tb_ysyx_25040129_imem_rd_slave;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 1024;
    localparam int          MAXD  = 7;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          NI    = 3;  // 0: LATENCY=0, 1: LATENCY=3, 2: RAND_DELAY=1

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] araddr_a  [NI];
    logic        arvalid_a [NI];
    logic        arready_a [NI];
    logic [31:0] rdata_a   [NI];
    logic [1:0]  rresp_a   [NI];
    logic        rvalid_a  [NI];
    logic        rready_a  [NI];
    logic        wr_en_a   [NI];
    logic [31:0] wr_addr_a [NI];
    logic [31:0] wr_data_a [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ysyx_25040129_imem_rd_slave #(
            .BASE_ADDR (BASE),
            .DEPTH     (DEPTH),
            .LATENCY   (g == 0 ? 0 : 3),
            .RAND_DELAY(g == 2),
            .MAX_DELAY (MAXD),
            .LFSR_SEED (SEED),
            .INIT_FILE ("")
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .araddr (araddr_a[g]),
            .arvalid(arvalid_a[g]),
            .arready(arready_a[g]),
            .rdata  (rdata_a[g]),
            .rresp  (rresp_a[g]),
            .rvalid (rvalid_a[g]),
            .rready (rready_a[g]),
            .wr_en  (wr_en_a[g]),
            .wr_addr(wr_addr_a[g]),
            .wr_data(wr_data_a[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: word array per instance plus the delay generator sequence.
    logic [31:0] mmem [NI][DEPTH];
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        int unsigned x;
        int unsigned fb;
        x  = v;
        fb = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
        return 16'((x >> 1) | (fb << 15));
    endfunction

    always @(posedge clk) m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);

    function automatic logic [1:0] ref_resp(input logic [31:0] a);
        if (a % 4 != 0) return 2'b10;
        if (a < BASE || a >= BASE + 32'(DEPTH * 4)) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_data(input int k, input logic [31:0] a);
        if (ref_resp(a) != 2'b00) return 32'h0;
        return mmem[k][int'((a - BASE) / 4)];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic backdoor(input int k, input logic [31:0] a, input logic [31:0] d);
        wr_en_a[k]   = 1'b1;
        wr_addr_a[k] = a;
        wr_data_a[k] = d;
        tick();
        wr_en_a[k] = 1'b0;
        if (ref_resp(a) == 2'b00) mmem[k][int'((a - BASE) / 4)] = d;
    endtask

    // One full read: AR handshake, wait for the beat, hold rready low 'hold' cycles, retire it.
    // wr_at > 0 pulses a backdoor write in that cycle (counted from the handshake edge).
    task automatic read_txn(input int k, input logic [31:0] a, input int hold,
                            input int wr_at, input logic [31:0] wa, input logic [31:0] wd,
                            output logic [31:0] data, output logic [1:0] resp, output int lat,
                            output logic [15:0] hs_lfsr, output bit timeout, output bit proto_err);
        int cyc;
        timeout   = 1'b0;
        proto_err = 1'b0;
        data      = 32'h0;
        resp      = 2'b00;
        lat       = -1;
        araddr_a[k]  = a;
        arvalid_a[k] = 1'b1;
        rready_a[k]  = (hold == 0);
        wr_addr_a[k] = wa;
        wr_data_a[k] = wd;
        cyc = 0;
        while (!arready_a[k] && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!arready_a[k]) begin
            arvalid_a[k] = 1'b0;
            timeout = 1'b1;
            return;
        end
        hs_lfsr = m_lfsr;
        cyc = 0;
        do begin
            tick();
            cyc++;
            arvalid_a[k] = 1'b0;
            wr_en_a[k]   = (cyc == wr_at);
            if (arready_a[k]) proto_err = 1'b1;
        end while (!rvalid_a[k] && cyc < 40);
        wr_en_a[k] = 1'b0;
        if (wr_at > 0 && wr_at < cyc && ref_resp(wa) == 2'b00) mmem[k][int'((wa - BASE) / 4)] = wd;
        if (!rvalid_a[k]) begin
            timeout = 1'b1;
            return;
        end
        lat  = cyc - 1;
        data = rdata_a[k];
        resp = rresp_a[k];
        for (int i = 0; i < hold; i++) begin
            tick();
            if (rvalid_a[k] !== 1'b1 || rdata_a[k] !== data || rresp_a[k] !== resp) proto_err = 1'b1;
            if (arready_a[k]) proto_err = 1'b1;
        end
        rready_a[k] = 1'b1;
        tick();
        rready_a[k] = 1'b0;
        if (rvalid_a[k] !== 1'b0 || arready_a[k] !== 1'b1) proto_err = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (arready_a[k] !== 1'b0 || rvalid_a[k] !== 1'b0 || rdata_a[k] !== 32'h0 || rresp_a[k] !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: arready=%b rvalid=%b rdata=%h rresp=%b, want 0 0 0 00",
                         k, arready_a[k], rvalid_a[k], rdata_a[k], rresp_a[k]);
            end
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (arready_a[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset_arready inst%0d: got %b want 1", k, arready_a[k]);
            end
        end
    endtask

    task automatic preload_all();
        logic [31:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            for (int k = 0; k < NI; k++) begin
                wr_en_a[k]   = 1'b1;
                wr_addr_a[k] = BASE + 32'(i * 4);
                wr_data_a[k] = d;
                mmem[k][i]   = d;
            end
            tick();
        end
        for (int k = 0; k < NI; k++) wr_en_a[k] = 1'b0;
    endtask

    task automatic test_latency0();
        logic [31:0] d;
        logic [31:0] a;
        logic [1:0]  r;
        logic [15:0] hl;
        int          lat;
        bit          to, pe;
        backdoor(0, BASE, 32'h0000_0413);
        read_txn(0, BASE, 0, 0, 0, 0, d, r, lat, hl, to, pe);
        n_tests++;
        if (to || pe || lat != 0 || d !== 32'h0000_0413 || r !== 2'b00) begin
            n_fail++;
            $display("FAIL lat0_first: to=%0d pe=%0d lat=%0d data=%h resp=%b, want lat=0 data=00000413 resp=00",
                     to, pe, lat, d, r);
        end
        for (int i = 0; i < 6; i++) begin
            a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            read_txn(0, a, int'($urandom_range(0, 2)), 0, 0, 0, d, r, lat, hl, to, pe);
            n_tests++;
            if (to || pe || lat != 0 || d !== ref_data(0, a) || r !== 2'b00) begin
                n_fail++;
                $display("FAIL lat0_rand addr=%h: to=%0d pe=%0d lat=%0d data=%h resp=%b, want lat=0 data=%h resp=00",
                         a, to, pe, lat, d, r, ref_data(0, a));
            end
        end
    endtask

    task automatic test_latency3_hold();
        logic [31:0] d;
        logic [31:0] a;
        logic [1:0]  r;
        logic [15:0] hl;
        int          lat;
        bit          to, pe;
        for (int i = 0; i < 3; i++) begin
            a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            read_txn(1, a, 4, 0, 0, 0, d, r, lat, hl, to, pe);
            n_tests++;
            if (to || pe || lat != 3 || d !== ref_data(1, a) || r !== 2'b00) begin
                n_fail++;
                $display("FAIL lat3_hold addr=%h: to=%0d pe=%0d lat=%0d data=%h resp=%b, want lat=3 data=%h resp=00",
                         a, to, pe, lat, d, r, ref_data(1, a));
            end
        end
    endtask

    task automatic test_decode();
        logic [31:0] addrs [8];
        logic [31:0] d;
        logic [1:0]  r;
        logic [15:0] hl;
        int          lat;
        bit          to, pe;
        addrs = '{32'h3000_0002, 32'h3000_1000, 32'h2FFF_FFFC, 32'h3000_0FFC,
                  32'h3000_1002, 32'hFFFF_FFFF, 32'h3000_0000, 32'h3000_0004};
        // Backdoor writes that must be dropped: out of range and misaligned.
        backdoor(0, 32'h3000_1000, 32'hDEAD_0001);
        backdoor(0, 32'h3000_0006, 32'hDEAD_0002);
        for (int i = 0; i < 8; i++) begin
            read_txn(0, addrs[i], 1, 0, 0, 0, d, r, lat, hl, to, pe);
            n_tests++;
            if (to || pe || lat != 0 || d !== ref_data(0, addrs[i]) || r !== ref_resp(addrs[i])) begin
                n_fail++;
                $display("FAIL decode addr=%h: to=%0d pe=%0d lat=%0d data=%h resp=%b, want data=%h resp=%b",
                         addrs[i], to, pe, lat, d, r, ref_data(0, addrs[i]), ref_resp(addrs[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] a;
        logic [1:0]  r;
        logic [15:0] hl;
        int          lat, exp_d, beats, bad;
        bit          to, pe;
        beats = 0;
        bad   = 0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            read_txn(2, a, 0, 0, 0, 0, d, r, lat, hl, to, pe);
            if (!to) beats++;
            exp_d = (int'(hl) % 16 > MAXD) ? MAXD : int'(hl) % 16;
            n_tests++;
            if (to || pe || lat != exp_d || d !== ref_data(2, a) || r !== ref_resp(a)) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL rand_fetch #%0d addr=%h: to=%0d pe=%0d D=%0d data=%h resp=%b, want D=%0d data=%h resp=%b",
                             i, a, to, pe, lat, d, r, exp_d, ref_data(2, a), ref_resp(a));
            end
        end
        n_tests++;
        if (beats != 1000) begin
            n_fail++;
            $display("FAIL rand_beat_count: got %0d want 1000", beats);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        logic [15:0] hl;
        int          lat, seen;
        bit          to, pe;
        araddr_a[1]  = BASE + 32'h8;
        arvalid_a[1] = 1'b1;
        rready_a[1]  = 1'b1;
        tick();
        arvalid_a[1] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (rvalid_a[1] !== 1'b0 || arready_a[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_state: rvalid=%b arready=%b want 0 0", rvalid_a[1], arready_a[1]);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (arready_a[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_idle: arready=%b want 1", arready_a[1]);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rvalid_a[1]) seen++;
        end
        rready_a[1] = 1'b0;
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL mid_reset_dropped: stray rvalid cycles=%0d want 0", seen);
        end
        read_txn(1, BASE + 32'hC, 0, 0, 0, 0, d, r, lat, hl, to, pe);
        n_tests++;
        if (to || pe || lat != 3 || d !== ref_data(1, BASE + 32'hC) || r !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_next_read: to=%0d pe=%0d lat=%0d data=%h resp=%b, want lat=3 data=%h resp=00",
                     to, pe, lat, d, r, ref_data(1, BASE + 32'hC));
        end
    endtask

    task automatic test_write_race();
        logic [31:0] d, expv, nv;
        logic [1:0]  r;
        logic [15:0] hl;
        int          lat;
        bit          to, pe;
        // Write during DELAY: the pending read sees the new word.
        nv = $urandom;
        read_txn(1, BASE + 32'h10, 0, 1, BASE + 32'h10, nv, d, r, lat, hl, to, pe);
        n_tests++;
        if (to || pe || d !== nv || r !== 2'b00) begin
            n_fail++;
            $display("FAIL write_in_delay: to=%0d pe=%0d data=%h resp=%b, want data=%h resp=00", to, pe, d, r, nv);
        end
        // Write on the capture edge: read returns the old word.
        expv = mmem[1][4];
        nv   = ~expv;
        read_txn(1, BASE + 32'h10, 0, 3, BASE + 32'h10, nv, d, r, lat, hl, to, pe);
        n_tests++;
        if (to || pe || d !== expv || r !== 2'b00) begin
            n_fail++;
            $display("FAIL write_at_capture: to=%0d pe=%0d data=%h resp=%b, want data=%h resp=00", to, pe, d, r, expv);
        end
        read_txn(1, BASE + 32'h10, 0, 0, 0, 0, d, r, lat, hl, to, pe);
        n_tests++;
        if (to || pe || d !== nv) begin
            n_fail++;
            $display("FAIL write_at_capture_landed: to=%0d pe=%0d data=%h want %h", to, pe, d, nv);
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            araddr_a[k]  = 32'h0;
            arvalid_a[k] = 1'b0;
            rready_a[k]  = 1'b0;
            wr_en_a[k]   = 1'b0;
            wr_addr_a[k] = 32'h0;
            wr_data_a[k] = 32'h0;
        end
        test_reset();
        preload_all();
        test_latency0();
        test_latency3_hold();
        test_decode();
        test_back_to_back();
        test_reset_mid();
        test_write_race();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
